// File: rtl/pu_flow_pd_req.sv
// -----------------------------------------------------------------------------
// pu_flow_pd_req
//
// Purpose:
//   Queues local commands for the flow PD memory. Commands are issued one at a
//   time, and each completion is returned to a local consumer. A small FIFO
//   buffers commands. A four-state FSM (IDLE, ISSUE, WAIT, RSP) keeps exactly
//   one request outstanding. It holds the request payload stable until the
//   memory answers, then presents the completion until the consumer accepts it.
//   The memory-select field of every outgoing address is forced to the flow
//   memory code.
//
// Optional feature:
//   PU_FLOW_PD_REQ_TIMEOUT_EN - when defined, an 8-bit watchdog ends the WAIT
//   state after TIMEOUT_CYC cycles without io_ack. The resulting completion
//   has rsp_err=1. When undefined, WAIT ends only on io_ack and rsp_err is
//   always 0.
//
// Command layout (cmd / io_cmd), MSB to LSB:
//   { fid[`PU_FID_NBITS], addr[`PU_ADDR_NBITS], wr, wdata[WIDTH_NBITS] }
//
// Ports:
//   clk          - clock, all logic on rising edge
//   `RESET_SIG   - asynchronous active-low reset (rst_n by default)
//   cmd_valid    - local command present
//   cmd          - command {fid, addr, wr, wdata}
//   cmd_ready    - queue can accept a command (not full)
//   io_req       - single-cycle request pulse to the flow PD memory
//   io_cmd       - request payload, address memory-select forced
//   io_ack       - memory response
//   io_ack_data  - read data, valid with io_ack
//   rsp_valid    - completion available
//   rsp_data     - read data (0 for writes and timeouts)
//   rsp_wr       - completed command was a write
//   rsp_err      - completion caused by timeout
//   rsp_ready    - consumer accepts the completion
//   busy         - queue non-empty or FSM not idle
// -----------------------------------------------------------------------------

`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 16
`endif
`ifndef PU_FID_NBITS
`define PU_FID_NBITS 4
`endif
`ifndef PU_ADDR_NBITS
`define PU_ADDR_NBITS 16
`endif
`ifndef PU_MEM_MULTI_DEPTH_RANGE
`define PU_MEM_MULTI_DEPTH_RANGE 15:12
`endif
`ifndef PU_FLOW_MEM
`define PU_FLOW_MEM 4'h3
`endif
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

module pu_flow_pd_req #(
    parameter int WIDTH_NBITS  = `PU_WIDTH_NBITS,
    parameter int QDEPTH_NBITS = 2,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                                                  clk,
    input  logic                                                  `RESET_SIG,
    input  logic                                                  cmd_valid,
    input  logic [`PU_FID_NBITS+`PU_ADDR_NBITS+WIDTH_NBITS:0]     cmd,
    output logic                                                  cmd_ready,
    output logic                                                  io_req,
    output logic [`PU_FID_NBITS+`PU_ADDR_NBITS+WIDTH_NBITS:0]     io_cmd,
    input  logic                                                  io_ack,
    input  logic [WIDTH_NBITS-1:0]                                io_ack_data,
    output logic                                                  rsp_valid,
    output logic [WIDTH_NBITS-1:0]                                rsp_data,
    output logic                                                  rsp_wr,
    output logic                                                  rsp_err,
    input  logic                                                  rsp_ready,
    output logic                                                  busy
);

    localparam int CMD_NBITS = `PU_FID_NBITS + `PU_ADDR_NBITS + 1 + WIDTH_NBITS;
    localparam int DEPTH     = 1 << QDEPTH_NBITS;
    localparam int WR_BIT    = WIDTH_NBITS;
    localparam int ADDR_LO   = WIDTH_NBITS + 1;
    localparam int ADDR_HI   = ADDR_LO + `PU_ADDR_NBITS - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RSP   = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------
    logic [CMD_NBITS-1:0]      fifo_mem_r [DEPTH];
    logic [QDEPTH_NBITS-1:0]   wr_ptr_r;
    logic [QDEPTH_NBITS-1:0]   rd_ptr_r;
    logic [QDEPTH_NBITS:0]     count_r;
    logic                      full_s;
    logic                      empty_s;
    logic                      push_s;
    logic                      pop_s;

    assign full_s  = (count_r == (QDEPTH_NBITS+1)'(DEPTH));
    assign empty_s = (count_r == {(QDEPTH_NBITS+1){1'b0}});
    assign push_s  = cmd_valid & ~full_s;

    // FIFO storage, pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge `RESET_SIG) begin
        if (!`RESET_SIG) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {CMD_NBITS{1'b0}};
            end
            wr_ptr_r <= {QDEPTH_NBITS{1'b0}};
            rd_ptr_r <= {QDEPTH_NBITS{1'b0}};
            count_r  <= {(QDEPTH_NBITS+1){1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= cmd;
                wr_ptr_r             <= wr_ptr_r + QDEPTH_NBITS'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + QDEPTH_NBITS'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (QDEPTH_NBITS+1)'(1);
                2'b01:   count_r <= count_r - (QDEPTH_NBITS+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Head of queue with the memory-select field forced to the flow memory
    // ---------------------------------------------------------------------
    logic [CMD_NBITS-1:0]      head_raw_s;
    logic [`PU_ADDR_NBITS-1:0] head_addr_s;
    logic [CMD_NBITS-1:0]      head_s;

    // Rebuild the head command around the re-targeted address
    always_comb begin
        head_raw_s                            = fifo_mem_r[rd_ptr_r];
        head_addr_s                           = head_raw_s[ADDR_HI:ADDR_LO];
        head_addr_s[`PU_MEM_MULTI_DEPTH_RANGE] = `PU_FLOW_MEM;
        head_s = {head_raw_s[CMD_NBITS-1:ADDR_HI+1], head_addr_s, head_raw_s[ADDR_LO-1:0]};
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    state_t state_r;
    state_t state_nxt_s;
    logic   timeout_s;

`ifdef PU_FLOW_PD_REQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] to_cnt_r;

    // The counter reads k-1 in the k-th WAIT cycle, so timeout_s fires in cycle TIMEOUT_CYC
    assign timeout_s = (state_r == ST_WAIT) && (to_cnt_r == TO_LAST);

    // Watchdog: zero outside WAIT, counting every WAIT cycle
    always_ff @(posedge clk or negedge `RESET_SIG) begin
        if (!`RESET_SIG) begin
            to_cnt_r <= 8'd0;
        end else if (state_r == ST_WAIT) begin
            to_cnt_r <= to_cnt_r + 8'd1;
        end else begin
            to_cnt_r <= 8'd0;
        end
    end
`else
    // TIMEOUT_CYC has no effect without the watchdog; both branches are identical
    if (TIMEOUT_CYC > 0) begin : g_no_timeout
        assign timeout_s = 1'b0;
    end else begin : g_no_timeout_zero
        assign timeout_s = 1'b0;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge `RESET_SIG) begin
        if (!`RESET_SIG) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and queue pop
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = ST_ISSUE;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                // io_ack also covers the same-cycle timeout case, so ack wins
                if (io_ack || timeout_s) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------------
    logic                  io_req_r;
    logic [CMD_NBITS-1:0]  io_cmd_r;
    logic                  rsp_valid_r;
    logic [WIDTH_NBITS-1:0] rsp_data_r;
    logic                  rsp_wr_r;
    logic                  rsp_err_r;

    // Request pulse, payload hold register and completion registers
    always_ff @(posedge clk or negedge `RESET_SIG) begin
        if (!`RESET_SIG) begin
            io_req_r    <= 1'b0;
            io_cmd_r    <= {CMD_NBITS{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {WIDTH_NBITS{1'b0}};
            rsp_wr_r    <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            // High only during the single ISSUE cycle
            io_req_r <= (state_nxt_s == ST_ISSUE);
            // Payload is loaded only on pop, so it stays stable through ISSUE and WAIT
            if (pop_s) begin
                io_cmd_r <= head_s;
            end
            if ((state_r == ST_WAIT) && (state_nxt_s == ST_RSP)) begin
                rsp_valid_r <= 1'b1;
                rsp_wr_r    <= io_cmd_r[WR_BIT];
                if (io_ack) begin
                    rsp_err_r  <= 1'b0;
                    rsp_data_r <= io_cmd_r[WR_BIT] ? {WIDTH_NBITS{1'b0}} : io_ack_data;
                end else begin
                    rsp_err_r  <= 1'b1;
                    rsp_data_r <= {WIDTH_NBITS{1'b0}};
                end
            end else if ((state_r == ST_RSP) && (state_nxt_s == ST_IDLE)) begin
                rsp_valid_r <= 1'b0;
                rsp_data_r  <= {WIDTH_NBITS{1'b0}};
                rsp_wr_r    <= 1'b0;
                rsp_err_r   <= 1'b0;
            end
        end
    end

    assign cmd_ready = ~full_s;
    assign io_req    = io_req_r;
    assign io_cmd    = io_cmd_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_wr    = rsp_wr_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = ~empty_s | (state_r != ST_IDLE);

endmodule
